// File: rtl/my_ram_8_ctrl.sv
// my_ram_8_ctrl
//   Eight-word register bank with a valid/ready request/response front end
//   and a hardware clear sequencer. All stored words are exported on a flat
//   bus for the downstream 8-way mux tree.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  request present
//   req_ready  block can accept a request this cycle (combinational)
//   req_we     1 = write, 0 = read
//   req_addr   word address
//   req_wdata  write data
//   rsp_valid  read response present
//   rsp_ready  consumer accepts response
//   rsp_data   read data (holds last value after the handshake)
//   clr        level request to zero all words
//   busy       clear sequence in progress
//   words      all stored words; word k at [WIDTH*k +: WIDTH]
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | accepting requests; clr starts a clear sequence
// RSP   | read response held until rsp_valid && rsp_ready
// CLEAR | zeroing one word per cycle, ascending address
module my_ram_8_ctrl #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_we,
    input  logic [ADDR_W-1:0]              req_addr,
    input  logic [WIDTH-1:0]               req_wdata,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [WIDTH-1:0]               rsp_data,
    input  logic                           clr,
    output logic                           busy,
    output logic [WIDTH*(2**ADDR_W)-1:0]   words
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RSP   = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic              rsp_valid_q;
    logic [WIDTH-1:0]  rsp_data_q;
    logic              busy_q;

    // clr wins over a simultaneous request; rst_n gates ready low during reset.
    assign req_ready = (state_q == IDLE) && !clr && rst_n;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;

    for (genvar k = 0; k < DEPTH; k++) begin : g_words
        assign words[WIDTH*k +: WIDTH] = mem_q[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr) begin
                        state_q <= CLEAR;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else if (req_valid) begin
                        if (req_we) begin
                            mem_q[req_addr] <= req_wdata;
                        end else begin
                            rsp_data_q  <= mem_q[req_addr];
                            rsp_valid_q <= 1'b1;
                            state_q     <= RSP;
                        end
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                CLEAR: begin
                    mem_q[cnt_q] <= '0;
                    cnt_q        <= cnt_q + 1'b1;
                    // Counter wraps to 0 as the last word is cleared.
                    if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
